// File: rtl/image_stream_fifo.sv
// image_stream_fifo: first-word-fall-through token FIFO between a
// SEND/RDY/ACK producer port and a SEND/ACK consumer port.
// In1_RDY and Out1_SEND are registered from the occupancy that the next
// cycle will start with. Out1_DATA is a register holding the head token.
module image_stream_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 16
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     In1_SEND,
   input  logic [DATA_W-1:0]        In1_DATA,
   input  logic [15:0]              In1_COUNT,
   output logic                     In1_RDY,
   output logic                     In1_ACK,
   output logic                     Out1_SEND,
   output logic [DATA_W-1:0]        Out1_DATA,
   output logic [15:0]              Out1_COUNT,
   input  logic                     Out1_ACK,
   output logic [$clog2(DEPTH):0]   LEVEL
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic [LW-1:0]     level, level_nxt, remain;
   logic              rdy_q, send_q;
   logic [DATA_W-1:0] data_q, head_nxt;
   logic              push, pop;

   // The producer token count carries no information this block needs.
   logic unused_count;
   assign unused_count = ^In1_COUNT;

   // Handshakes qualify on the registered flags, so a pop never opens a
   // slot for a push in the same cycle.
   assign push = In1_SEND & rdy_q & RESET;
   assign pop  = Out1_ACK & send_q & RESET;

   assign In1_ACK    = push;
   assign In1_RDY    = rdy_q;
   assign Out1_SEND  = send_q;
   assign Out1_DATA  = data_q;
   assign Out1_COUNT = {15'h0, send_q};
   assign LEVEL      = level;

   // Next occupancy, pointers and the head token the output register loads.
   always_comb begin
      level_nxt = level;
      if (push && !pop)
         level_nxt = level + LW'(1);
      else if (pop && !push)
         level_nxt = level - LW'(1);

      wr_nxt = push ? wr_ptr + AW'(1) : wr_ptr;
      rd_nxt = pop  ? rd_ptr + AW'(1) : rd_ptr;

      // Tokens already stored that survive this cycle's pop; when none
      // survive, the new head can only be the token being pushed now.
      remain   = level - LW'(pop);
      head_nxt = data_q;
      if (level_nxt != '0) begin
         if (remain == '0)
            head_nxt = In1_DATA;
         else
            head_nxt = mem[rd_nxt];
      end
   end

   // Token storage; written only on an accepted push.
   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr] <= In1_DATA;
   end

   // Control state and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         rdy_q  <= 1'b0;
         send_q <= 1'b0;
         data_q <= '0;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         level  <= level_nxt;
         rdy_q  <= (level_nxt < DEPTH_L);
         send_q <= (level_nxt != '0);
         data_q <= head_nxt;
      end
   end

endmodule
